// File: rtl/mel_filterbank.sv
// rtl/mel_filterbank.sv - triangular mel filterbank over a runtime-loaded per-bin LUT
// Optional MEL_LOG_EN: fixed-point log2 output with one extra register stage.
module mel_filterbank #(
  parameter int WIDTH     = 16,
  parameter int N_FFT     = 512,
  parameter int N_MEL     = 40,
  parameter int ACC_WIDTH = 24,
  parameter int OUT_SHIFT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lut_en,
  input  logic [8+WIDTH-1:0] lut_data,
  output logic               lut_done,
  input  logic               den,
  input  logic [WIDTH-1:0]   din,
  output logic               mel_en,
  output logic [7:0]         mel_idx,
  output logic [WIDTH-1:0]   mel_data
);
  localparam int N_BINS = N_FFT / 2 + 1;
  localparam int AW     = $clog2(N_BINS);
  localparam int KW     = $clog2(N_FFT);
  localparam int PW     = 2 * WIDTH;

  logic [7:0]       lut_bnd [N_BINS];
  logic [WIDTH-1:0] lut_wt  [N_BINS];
  logic [AW-1:0]    lut_addr;
  logic [KW-1:0]    bin_cnt;
  logic             accept;

  function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] v);
    logic [ACC_WIDTH:0] s;
    s = {1'b0, a} + (ACC_WIDTH+1)'(v);
    return s[ACC_WIDTH] ? '1 : s[ACC_WIDTH-1:0];
  endfunction

  assign accept = den && lut_done;

  always_ff @(posedge clk) begin
    if (lut_en && !den) begin
      lut_bnd[lut_addr] <= lut_data[8+WIDTH-1:WIDTH];
      lut_wt[lut_addr]  <= lut_data[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_addr <= '0;
      lut_done <= 1'b0;
      bin_cnt  <= '0;
    end else begin
      if (lut_en && !den) begin
        if (lut_addr == AW'(N_BINS - 1)) begin
          lut_addr <= '0;
          lut_done <= 1'b1;
        end else begin
          lut_addr <= lut_addr + 1'b1;
        end
      end
      if (accept)
        bin_cnt <= (bin_cnt == KW'(N_FFT - 1)) ? '0 : bin_cnt + 1'b1;
    end
  end

  // Stage 1: LUT lookup and both weighted products
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_wt;
  logic [WIDTH:0]   rd_cw;
  logic [PW-1:0]    prod_r;
  logic [PW:0]      prod_f;

  assign rd_addr = (bin_cnt < KW'(N_BINS)) ? bin_cnt[AW-1:0] : '0;
  assign rd_wt   = lut_wt[rd_addr];
  assign rd_cw   = {1'b1, {WIDTH{1'b0}}} - {1'b0, rd_wt};
  assign prod_r  = PW'(rd_wt) * PW'(din);
  assign prod_f  = (PW+1)'(rd_cw) * (PW+1)'(din);

  logic             s1_vld;
  logic [KW-1:0]    s1_bin;
  logic [7:0]       s1_bnd;
  logic [WIDTH-1:0] s1_rise, s1_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_bin  <= '0;
      s1_bnd  <= '0;
      s1_rise <= '0;
      s1_fall <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_bin  <= bin_cnt;
        s1_bnd  <= lut_bnd[rd_addr];
        s1_rise <= prod_r[PW-1:WIDTH];
        s1_fall <= prod_f[PW-1:WIDTH];
      end
    end
  end

  // Stage 2: band accumulation; nxt counts bands already emitted this frame
  logic [7:0]           cur, nxt;
  logic [ACC_WIDTH-1:0] acc_lo, acc_hi, emit_acc;
  logic                 s1_in, step, emit;

  assign s1_in = s1_bin < KW'(N_BINS);
  assign step  = s1_vld && s1_in && (s1_bnd != cur);

  always_comb begin
    emit     = 1'b0;
    emit_acc = '0;
    if (step && cur != 8'd0) begin
      emit     = 1'b1;
      emit_acc = acc_lo;
    end else if (s1_vld && !s1_in && nxt < 8'(N_MEL)) begin
      emit = 1'b1;
      if (cur != 8'd0 && nxt == cur - 8'd1)
        emit_acc = acc_lo;
      else if (nxt == cur)
        emit_acc = acc_hi;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur    <= '0;
      nxt    <= '0;
      acc_lo <= '0;
      acc_hi <= '0;
    end else if (s1_vld) begin
      if (s1_in) begin
        if (!step) begin
          if (cur != 8'd0)
            acc_lo <= sat_add(acc_lo, s1_fall);
          if (cur != 8'(N_MEL))
            acc_hi <= sat_add(acc_hi, s1_rise);
        end else begin
          acc_lo <= sat_add(acc_hi, s1_fall);
          acc_hi <= (s1_bnd != 8'(N_MEL)) ? ACC_WIDTH'(s1_rise) : '0;
          cur    <= s1_bnd;
          if (cur != 8'd0)
            nxt <= nxt + 8'd1;
        end
      end else if (nxt < 8'(N_MEL)) begin
        nxt <= nxt + 8'd1;
      end
      if (s1_bin == KW'(N_FFT - 1)) begin
        cur    <= '0;
        nxt    <= '0;
        acc_lo <= '0;
        acc_hi <= '0;
      end
    end
  end

`ifdef MEL_LOG_EN
  localparam int LI = $clog2(ACC_WIDTH);
  localparam int FW = WIDTH - LI;

  // Integer part is the leading-one position; fraction is the bits below it, left-aligned.
  function automatic logic [WIDTH-1:0] log_fx(input logic [ACC_WIDTH-1:0] a);
    logic [LI-1:0]           p;
    logic [ACC_WIDTH+FW-1:0] e;
    p = '0;
    for (int i = 1; i < ACC_WIDTH; i++)
      if (a[i]) p = LI'(i);
    e = {a, {FW{1'b0}}} << (ACC_WIDTH - int'(p));
    return {p, e[ACC_WIDTH+FW-1 -: FW]};
  endfunction

  logic                 l_vld;
  logic [7:0]           l_idx;
  logic [ACC_WIDTH-1:0] l_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_vld    <= 1'b0;
      l_idx    <= '0;
      l_acc    <= '0;
      mel_en   <= 1'b0;
      mel_idx  <= '0;
      mel_data <= '0;
    end else begin
      l_vld  <= emit;
      mel_en <= l_vld;
      if (emit) begin
        l_idx <= nxt;
        l_acc <= emit_acc;
      end
      if (l_vld) begin
        mel_idx  <= l_idx;
        mel_data <= log_fx(l_acc);
      end
    end
  end
`else
  function automatic logic [WIDTH-1:0] lin_out(input logic [ACC_WIDTH-1:0] a);
    logic [ACC_WIDTH-1:0] s;
    s = a >> OUT_SHIFT;
    return (|s[ACC_WIDTH-1:WIDTH]) ? '1 : s[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mel_en   <= 1'b0;
      mel_idx  <= '0;
      mel_data <= '0;
    end else begin
      mel_en <= emit;
      if (emit) begin
        mel_idx  <= nxt;
        mel_data <= lin_out(emit_acc);
      end
    end
  end
`endif

endmodule
